// File: rtl/i2s_apb_feeder_if.sv
// Purpose : stream + APB signal bundle between the I2S feeder and its neighbours.
// Latency : none (wires only).
// Backpressure: carried by s_ready (input stream) and m_ready (output stream).
// Ports   : s_valid/s_data/s_ready   - Tx sample stream into the feeder
//           m_valid/m_data/m_ready   - Rx sample stream out of the feeder
//           psel/penable/pwrite/paddr/pwdata/prdata - APB towards the transceiver
// Modports: master = the feeder side, slave = everything around it.
interface i2s_apb_feeder_if;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_ready;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  modport master (
    input  s_valid, s_data, m_ready, prdata,
    output s_ready, m_valid, m_data, psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output s_valid, s_data, m_ready, prdata,
    input  s_ready, m_valid, m_data, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/i2s_apb_feeder.sv
// Purpose : APB master that polls the I2S transceiver status, then writes Tx samples
//           from the input stream or drains Rx samples into the output stream.
// Latency : s_valid to s_ready 3 cycles from IDLE; Tx write ends 2 cycles later (6-cycle period).
// Backpressure: s_ready only pulses when the Tx FIFO has room; no Rx read while m_valid is held.
// Ports   : pclk, preset (async, active high); en, rx_en enables;
//           bus (master modport): input/output streams and the APB master signals;
//           tx_count, rx_count (wrapping 16-bit transfer counts); busy (not IDLE).
module i2s_apb_feeder #(
  parameter logic [31:0] TX_ADDR   = 32'h0000_0004,
  parameter logic [31:0] RX_ADDR   = 32'h0000_0008,
  parameter logic [31:0] STAT_ADDR = 32'h0000_000C,
  parameter int          TXF_BIT   = 7,
  parameter int          RXE_BIT   = 2,
  parameter int          POLL_GAP  = 4
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                en,
  input  logic                rx_en,
  i2s_apb_feeder_if.master    bus,
  output logic [15:0]         tx_count,
  output logic [15:0]         rx_count,
  output logic                busy
);

  localparam logic [7:0] GAP_INIT = 8'(POLL_GAP);

  typedef enum logic [2:0] {
    IDLE,
    STAT_SETUP,
    STAT_ACCESS,
    DECIDE,
    TX_SETUP,
    TX_ACCESS,
    RX_SETUP,
    RX_ACCESS
  } state_t;

  state_t      state, nxt_state;

  // Only the two flag bits of the status word influence decisions, so only
  // those are kept from the status read.
  logic        stat_txf_q;
  logic        stat_rxe_q;

  logic [7:0]  gap_q;
  logic        rr_q;        // 0 = Tx preferred on the next tie
  logic        rr_nxt;

  logic        psel_q;
  logic        penable_q;
  logic        pwrite_q;
  logic [31:0] paddr_q;
  logic [31:0] pwdata_q;
  logic        m_valid_q;
  logic [31:0] m_data_q;
  logic [15:0] tx_cnt_q;
  logic [15:0] rx_cnt_q;

  logic        tx_ok;
  logic        rx_ok;
  logic        pick_tx;
  logic        pick_rx;
  logic        gap_load;

  // Next-state and decision logic
  always_comb begin
    nxt_state = state;
    pick_tx   = 1'b0;
    pick_rx   = 1'b0;
    gap_load  = 1'b0;
    rr_nxt    = rr_q;
    tx_ok     = bus.s_valid & ~stat_txf_q;
    rx_ok     = rx_en & ~m_valid_q & ~stat_rxe_q;

    case (state)
      IDLE: begin
        // A pending gap suppresses polling entirely, even with work waiting.
        if (gap_q == 8'd0 && en && (bus.s_valid || (rx_en && !m_valid_q)))
          nxt_state = STAT_SETUP;
      end
      STAT_SETUP:  nxt_state = STAT_ACCESS;
      STAT_ACCESS: nxt_state = DECIDE;
      DECIDE: begin
        if (tx_ok && rx_ok) begin
          pick_tx = ~rr_q;
          pick_rx = rr_q;
          rr_nxt  = ~rr_q;
        end else if (tx_ok) begin
          pick_tx = 1'b1;
          rr_nxt  = 1'b1;
        end else if (rx_ok) begin
          pick_rx = 1'b1;
          rr_nxt  = 1'b0;
        end else begin
          gap_load = 1'b1;
        end

        if (pick_tx)
          nxt_state = TX_SETUP;
        else if (pick_rx)
          nxt_state = RX_SETUP;
        else
          nxt_state = IDLE;
      end
      TX_SETUP:  nxt_state = TX_ACCESS;
      TX_ACCESS: nxt_state = IDLE;
      RX_SETUP:  nxt_state = RX_ACCESS;
      RX_ACCESS: nxt_state = IDLE;
      default:   nxt_state = IDLE;
    endcase
  end

  // State register, APB outputs and datapath
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state      <= IDLE;
      stat_txf_q <= 1'b0;
      stat_rxe_q <= 1'b0;
      gap_q      <= 8'd0;
      rr_q       <= 1'b0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= 32'd0;
      pwdata_q   <= 32'd0;
      m_valid_q  <= 1'b0;
      m_data_q   <= 32'd0;
      tx_cnt_q   <= 16'd0;
      rx_cnt_q   <= 16'd0;
    end else begin
      state <= nxt_state;
      rr_q  <= rr_nxt;

      if (state == STAT_ACCESS) begin
        stat_txf_q <= bus.prdata[TXF_BIT];
        stat_rxe_q <= bus.prdata[RXE_BIT];
      end

      if (gap_load)
        gap_q <= GAP_INIT;
      else if (state == IDLE && gap_q != 8'd0)
        gap_q <= gap_q - 8'd1;

      // APB strobes are registered from the next state so they are clean
      // flop outputs and drop immediately on an asynchronous reset.
      psel_q    <= (nxt_state == STAT_SETUP) || (nxt_state == STAT_ACCESS) ||
                   (nxt_state == TX_SETUP)   || (nxt_state == TX_ACCESS)   ||
                   (nxt_state == RX_SETUP)   || (nxt_state == RX_ACCESS);
      penable_q <= (nxt_state == STAT_ACCESS) || (nxt_state == TX_ACCESS) ||
                   (nxt_state == RX_ACCESS);

      // Address and direction load on SETUP entry and hold otherwise.
      case (nxt_state)
        STAT_SETUP: begin
          paddr_q  <= STAT_ADDR;
          pwrite_q <= 1'b0;
        end
        TX_SETUP: begin
          paddr_q  <= TX_ADDR;
          pwrite_q <= 1'b1;
        end
        RX_SETUP: begin
          paddr_q  <= RX_ADDR;
          pwrite_q <= 1'b0;
        end
        default: ;
      endcase

      if (pick_tx)
        pwdata_q <= bus.s_data;

      if (state == TX_ACCESS)
        tx_cnt_q <= tx_cnt_q + 16'd1;

      // A new Rx read never starts while m_valid is set, so the set and
      // clear conditions below cannot coincide.
      if (state == RX_ACCESS) begin
        m_data_q  <= bus.prdata;
        m_valid_q <= 1'b1;
        rx_cnt_q  <= rx_cnt_q + 16'd1;
      end else if (m_valid_q && bus.m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  // s_ready is a single-cycle pulse in DECIDE; the sample is taken on that edge.
  assign bus.s_ready = pick_tx;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.psel    = psel_q;
  assign bus.penable = penable_q;
  assign bus.pwrite  = pwrite_q;
  assign bus.paddr   = paddr_q;
  assign bus.pwdata  = pwdata_q;
  assign tx_count    = tx_cnt_q;
  assign rx_count    = rx_cnt_q;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_i2s_apb_feeder.sv
// Purpose : self-checking bench for i2s_apb_feeder: cycle table plus corner sequences.
// Latency : n/a.
// Backpressure: the bench plays both stream ends and a zero-wait APB slave.
module tb_i2s_apb_feeder;
  localparam logic [31:0] SD = 32'hA5A5_0001;
  localparam logic [31:0] MD = 32'h0012_3456;
  localparam logic [31:0] AC = 32'h0000_000C;
  localparam logic [31:0] A4 = 32'h0000_0004;
  localparam logic [31:0] A8 = 32'h0000_0008;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        en = 1'b0;
  logic        rx_en = 1'b0;
  logic [15:0] tx_count;
  logic [15:0] rx_count;
  logic        busy;
  logic [31:0] stat_val = 32'd0;
  logic [31:0] rx_word = MD;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int sready_cnt = 0;

  i2s_apb_feeder_if bus ();

  i2s_apb_feeder dut (
    .pclk     (pclk),
    .preset   (preset),
    .en       (en),
    .rx_en    (rx_en),
    .bus      (bus.master),
    .tx_count (tx_count),
    .rx_count (rx_count),
    .busy     (busy)
  );

  always #5 pclk = ~pclk;

  // Zero-wait APB slave: status or Rx word depending on address.
  always_comb begin
    if (bus.paddr == AC)
      bus.prdata = stat_val;
    else if (bus.paddr == A8)
      bus.prdata = rx_word;
    else
      bus.prdata = 32'hDEAD_BEEF;
  end

  typedef struct {
    int          cyc;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  xfer_t log_q[$];
  xfer_t xl;

  always @(posedge pclk) cyc <= cyc + 1;

  always @(negedge pclk) begin
    if (bus.s_ready) sready_cnt = sready_cnt + 1;
    if (bus.psel && bus.penable) begin
      xl.cyc  = cyc;
      xl.wr   = bus.pwrite;
      xl.addr = bus.paddr;
      xl.data = bus.pwrite ? bus.pwdata : bus.prdata;
      log_q.push_back(xl);
    end
  end

  typedef struct {
    logic        sv, rxe, mr;
    logic        ps, pe, pw;
    logic [31:0] ad, wd;
    logic        sr, mv;
    logic [31:0] md;
    logic        bz;
    logic [15:0] tc, rc;
  } vec_t;

  vec_t vt[17];

  function automatic vec_t mk(logic sv, logic rxe, logic mr, logic ps, logic pe, logic pw,
                              logic [31:0] ad, logic [31:0] wd, logic sr, logic mv,
                              logic [31:0] md, logic bz, logic [15:0] tc, logic [15:0] rc);
    vec_t v;
    v.sv = sv; v.rxe = rxe; v.mr = mr; v.ps = ps; v.pe = pe; v.pw = pw;
    v.ad = ad; v.wd = wd; v.sr = sr; v.mv = mv; v.md = md; v.bz = bz;
    v.tc = tc; v.rc = rc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int count_data(input int base);
    int n = 0;
    for (int i = base; i < log_q.size(); i++)
      if (log_q[i].addr != AC) n++;
    return n;
  endfunction

  task automatic do_reset();
    preset = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data = 32'd0;
    bus.m_ready = 1'b0;
    rx_en = 1'b0;
    en = 1'b1;
    stat_val = 32'd0;
    repeat (2) @(posedge pclk);
    #1 preset = 1'b0;
  endtask

  // Waits for an s_ready pulse (sampled on the falling edge) within lim cycles.
  task automatic wait_sready(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge pclk);
      if (bus.s_ready) ok = 1'b1;
    end
  endtask

  initial begin
    bit ok;
    int base, s0, polls, last, wr_cnt;
    int pc[$];

    // One row per cycle: {s_valid, rx_en, m_ready} ->
    // {psel, penable, pwrite, paddr, pwdata, s_ready, m_valid, m_data, busy, tx_count, rx_count}
    vt[0]  = mk(1,0,0, 0,0,0, 32'd0, 32'd0, 0,0,32'd0, 0, 16'd0, 16'd0);
    vt[1]  = mk(1,0,0, 1,0,0, AC, 32'd0, 0,0,32'd0, 1, 16'd0, 16'd0);
    vt[2]  = mk(1,0,0, 1,1,0, AC, 32'd0, 0,0,32'd0, 1, 16'd0, 16'd0);
    vt[3]  = mk(1,0,0, 0,0,0, AC, 32'd0, 1,0,32'd0, 1, 16'd0, 16'd0);
    vt[4]  = mk(0,0,0, 1,0,1, A4, SD,    0,0,32'd0, 1, 16'd0, 16'd0);
    vt[5]  = mk(0,0,0, 1,1,1, A4, SD,    0,0,32'd0, 1, 16'd0, 16'd0);
    vt[6]  = mk(0,0,0, 0,0,1, A4, SD,    0,0,32'd0, 0, 16'd1, 16'd0);
    vt[7]  = mk(0,1,0, 0,0,1, A4, SD,    0,0,32'd0, 0, 16'd1, 16'd0);
    vt[8]  = mk(0,1,0, 1,0,0, AC, SD,    0,0,32'd0, 1, 16'd1, 16'd0);
    vt[9]  = mk(0,1,0, 1,1,0, AC, SD,    0,0,32'd0, 1, 16'd1, 16'd0);
    vt[10] = mk(0,1,0, 0,0,0, AC, SD,    0,0,32'd0, 1, 16'd1, 16'd0);
    vt[11] = mk(0,1,0, 1,0,0, A8, SD,    0,0,32'd0, 1, 16'd1, 16'd0);
    vt[12] = mk(0,1,0, 1,1,0, A8, SD,    0,0,32'd0, 1, 16'd1, 16'd0);
    vt[13] = mk(0,1,0, 0,0,0, A8, SD,    0,1,MD,    0, 16'd1, 16'd1);
    vt[14] = mk(0,1,0, 0,0,0, A8, SD,    0,1,MD,    0, 16'd1, 16'd1);
    vt[15] = mk(0,1,1, 0,0,0, A8, SD,    0,1,MD,    0, 16'd1, 16'd1);
    vt[16] = mk(0,0,0, 0,0,0, A8, SD,    0,0,MD,    0, 16'd1, 16'd1);

    do_reset();
    bus.s_data = SD;
    for (int i = 0; i < 17; i++) begin
      @(posedge pclk);
      #1;
      bus.s_valid = vt[i].sv;
      rx_en       = vt[i].rxe;
      bus.m_ready = vt[i].mr;
      @(negedge pclk);
      chk($sformatf("r%0d psel", i),     {31'd0, bus.psel},    {31'd0, vt[i].ps});
      chk($sformatf("r%0d penable", i),  {31'd0, bus.penable}, {31'd0, vt[i].pe});
      chk($sformatf("r%0d pwrite", i),   {31'd0, bus.pwrite},  {31'd0, vt[i].pw});
      chk($sformatf("r%0d paddr", i),    bus.paddr,            vt[i].ad);
      chk($sformatf("r%0d pwdata", i),   bus.pwdata,           vt[i].wd);
      chk($sformatf("r%0d s_ready", i),  {31'd0, bus.s_ready}, {31'd0, vt[i].sr});
      chk($sformatf("r%0d m_valid", i),  {31'd0, bus.m_valid}, {31'd0, vt[i].mv});
      chk($sformatf("r%0d m_data", i),   bus.m_data,           vt[i].md);
      chk($sformatf("r%0d busy", i),     {31'd0, busy},        {31'd0, vt[i].bz});
      chk($sformatf("r%0d tx_count", i), {16'd0, tx_count},    {16'd0, vt[i].tc});
      chk($sformatf("r%0d rx_count", i), {16'd0, rx_count},    {16'd0, vt[i].rc});
    end

    // Tx FIFO full: repeated polls 8 cycles apart (3 poll states + 4 gap + 1 IDLE), no s_ready.
    @(posedge pclk); #1;
    stat_val = 32'h0000_0080;
    bus.s_data = 32'hBEEF_0002;
    bus.s_valid = 1'b1;
    base = log_q.size();
    s0 = sready_cnt;
    repeat (40) @(posedge pclk);
    @(negedge pclk);
    pc.delete();
    for (int i = base; i < log_q.size(); i++)
      if (log_q[i].addr == AC && !log_q[i].wr) pc.push_back(log_q[i].cyc);
    polls = pc.size();
    chk("full poll count>=4", {31'd0, polls >= 4}, 32'd1);
    chk("full no data xfer", count_data(base), 32'd0);
    chk("full no s_ready", sready_cnt - s0, 32'd0);
    for (int i = 1; i < polls && i < 4; i++)
      chk($sformatf("full poll gap %0d", i), pc[i] - pc[i-1], 32'd8);
    stat_val = 32'd0;
    wait_sready(20, ok);
    chk("full->free s_ready", {31'd0, ok}, 32'd1);
    @(posedge pclk); #1 bus.s_valid = 1'b0;
    repeat (4) @(negedge pclk);
    last = log_q.size() - 1;
    chk("full->free wr addr", log_q[last].addr, A4);
    chk("full->free wr data", log_q[last].data, 32'hBEEF_0002);
    chk("full->free tx_count", {16'd0, tx_count}, 32'd2);

    // s_valid withdrawn during the status poll: no s_ready, no write.
    bus.s_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge pclk);
      if (bus.psel && !bus.penable && bus.paddr == AC) ok = 1'b1;
    end
    chk("withdraw poll seen", {31'd0, ok}, 32'd1);
    base = log_q.size();
    s0 = sready_cnt;
    @(posedge pclk); #1 bus.s_valid = 1'b0;
    repeat (12) @(negedge pclk);
    chk("withdraw no s_ready", sready_cnt - s0, 32'd0);
    chk("withdraw no write", count_data(base), 32'd0);
    chk("withdraw tx_count", {16'd0, tx_count}, 32'd2);

    // en low: no polls at all.
    en = 1'b0;
    bus.s_valid = 1'b1;
    rx_en = 1'b1;
    base = log_q.size();
    repeat (14) @(negedge pclk);
    chk("en low no xfer", log_q.size() - base, 32'd0);
    chk("en low busy", {31'd0, busy}, 32'd0);
    bus.s_valid = 1'b0;
    rx_en = 1'b0;
    en = 1'b1;

    // Both directions ready: strict Tx/Rx alternation starting with Tx.
    do_reset();
    bus.s_data = 32'hC0DE_0000;
    bus.s_valid = 1'b1;
    rx_en = 1'b1;
    bus.m_ready = 1'b1;
    base = log_q.size();
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge pclk);
      if (count_data(base) >= 8) ok = 1'b1;
    end
    chk("alt 8 xfers", {31'd0, ok}, 32'd1);
    @(posedge pclk); #1;
    bus.s_valid = 1'b0;
    rx_en = 1'b0;
    repeat (4) @(negedge pclk);
    wr_cnt = 0;
    for (int i = base; i < log_q.size() && wr_cnt < 8; i++) begin
      if (log_q[i].addr != AC) begin
        chk($sformatf("alt %0d addr", wr_cnt), log_q[i].addr, (wr_cnt % 2 == 0) ? A4 : A8);
        chk($sformatf("alt %0d dir", wr_cnt), {31'd0, log_q[i].wr}, (wr_cnt % 2 == 0) ? 32'd1 : 32'd0);
        wr_cnt++;
      end
    end
    chk("alt tx_count", {16'd0, tx_count}, 32'd4);
    chk("alt rx_count", {16'd0, rx_count}, 32'd4);

    // Reset during TX_ACCESS: everything drops at once, the write never counts.
    bus.s_data = 32'h1111_2222;
    bus.s_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge pclk);
      if (bus.psel && bus.penable && bus.pwrite) ok = 1'b1;
    end
    chk("rst tx_access seen", {31'd0, ok}, 32'd1);
    preset = 1'b1;
    #1;
    chk("rst psel", {31'd0, bus.psel}, 32'd0);
    chk("rst penable", {31'd0, bus.penable}, 32'd0);
    chk("rst s_ready", {31'd0, bus.s_ready}, 32'd0);
    chk("rst tx_count", {16'd0, tx_count}, 32'd0);
    chk("rst rx_count", {16'd0, rx_count}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    bus.s_valid = 1'b0;
    repeat (2) @(posedge pclk);
    #1 preset = 1'b0;
    repeat (4) @(negedge pclk);
    chk("rst tx_count after", {16'd0, tx_count}, 32'd0);

    // Counter wrap: preload 16'hFFFF, one more write wraps to zero.
    @(negedge pclk);
    force dut.tx_cnt_q = 16'hFFFF;
    @(posedge pclk);
    #1 release dut.tx_cnt_q;
    @(negedge pclk);
    chk("wrap preload", {16'd0, tx_count}, 32'h0000_FFFF);
    bus.s_data = 32'h5A5A_FFFF;
    bus.s_valid = 1'b1;
    wait_sready(20, ok);
    chk("wrap s_ready", {31'd0, ok}, 32'd1);
    @(posedge pclk); #1 bus.s_valid = 1'b0;
    repeat (4) @(negedge pclk);
    chk("wrap tx_count", {16'd0, tx_count}, 32'd0);
    last = log_q.size() - 1;
    chk("wrap wr data", log_q[last].data, 32'h5A5A_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end
endmodule
